line_mem_responder: RTL and testbench

- Off-chip backing-memory model and responder for the data-cache refill/write-back interface.
- Accepts one 256-bit line request at a time from the cache miss path (enable/write/address/data).
- Completes the request after a fixed latency and signals completion with a one-cycle acknowledge.
- Sits below dcache_top and serves as the memory the CPU top-level connects to in simulation and FPGA builds.

---
 rtl/line_mem_pkg.sv | 9 +
 rtl/line_mem_if.sv | 14 +
 rtl/line_mem_array.sv | 24 ++
 rtl/line_mem_responder.sv | 82 ++++++++
 tb/tb_line_mem_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared FSM states, line geometry constants and line-index helper.
package line_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam int LINE_BYTES = 32;
  localparam int OFFSET_BITS = 5;
  function automatic logic [31:0] idx_of(input logic [31:0] addr, input int depth);
    return (addr >> OFFSET_BITS) & 32'(depth - 1);
  endfunction
endpackage

// File: rtl/line_mem_if.sv
// line_mem_if: cache-miss-path line request/ack bus between requester and memory responder.
interface line_mem_if #(parameter int LINE_W = 256, parameter int ADDR_W = 32);
  logic              mem_enable_i;
  logic              mem_write_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              busy_o;
  modport master (output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  input  mem_ack_o, mem_data_o, busy_o);
  modport slave  (input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
                  output mem_ack_o, mem_data_o, busy_o);
endinterface

// File: rtl/line_mem_array.sv
// line_mem_array: DEPTH x LINE_W line storage, one sync write port and one sync read port.
// Storage is never reset; only the read register clears so the bus reads back zero after reset.
module line_mem_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [IW-1:0]     idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= wdata;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency backing-memory responder for dcache line refill/write-back.
// Optional LINE_MEM_STATS_EN adds saturating read/write ack counters.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  line_mem_if.slave   bus
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;
  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic              cap_write;
  logic [IW-1:0]     cap_idx;
  logic [LINE_W-1:0] cap_data;
  logic              idle, enter_ack, op_write;
  logic [IW-1:0]     op_idx;
  logic [LINE_W-1:0] op_data, rdata;
  always_comb begin
    idle      = state == IDLE;
    nxt       = idle ? (bus.mem_enable_i ? (LATENCY == 1 ? ACK : WAIT) : IDLE) :
                state == WAIT ? (cnt == CW'(1) ? ACK : WAIT) : IDLE;
    enter_ack = nxt == ACK;
    // With LATENCY=1 the array is accessed on the acceptance edge, before capture lands
    op_write  = idle ? bus.mem_write_i : cap_write;
    op_idx    = idle ? IW'(idx_of(32'(bus.mem_addr_i), DEPTH)) : cap_idx;
    op_data   = idle ? bus.mem_data_i : cap_data;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_data  <= '0;
    end else begin
      state <= nxt;
      if (idle && bus.mem_enable_i) begin
        cnt       <= CW'(LATENCY - 1);
        cap_write <= bus.mem_write_i;
        cap_idx   <= IW'(idx_of(32'(bus.mem_addr_i), DEPTH));
        cap_data  <= bus.mem_data_i;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
  line_mem_array #(.LINE_W(LINE_W), .DEPTH(DEPTH)) u_array (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wr_en (enter_ack && op_write),
    .rd_en (enter_ack && !op_write),
    .idx   (op_idx),
    .wdata (op_data),
    .rdata (rdata)
  );
  assign bus.mem_ack_o  = state == ACK;
  assign bus.busy_o     = !idle;
  assign bus.mem_data_o = rdata;
`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (state == ACK) begin
      if (!cap_write && rd_count_o != '1) rd_count_o <= rd_count_o + 32'd1;
      if (cap_write && wr_count_o != '1) wr_count_o <= wr_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: scoreboard bench for line_mem_responder (LATENCY=10 and LATENCY=1 instances).
module tb_line_mem_responder;
  import line_mem_pkg::*;
  localparam int LAT = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [255:0] model [512];
  logic [255:0] sb [$];
  logic [255:0] last_rd = '0;
  localparam logic [255:0] PAT3 = {32{8'hA5}};
  localparam logic [255:0] PAT7 = {8{32'h7777_0007}};
  localparam logic [255:0] PAT9 = {8{32'h9999_0009}};
  localparam logic [255:0] PAT2 = {16{16'h3C5A}};
  line_mem_if #(.LINE_W(256), .ADDR_W(32)) bus ();
  line_mem_if #(.LINE_W(256), .ADDR_W(32)) bus2 ();
`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd1, wr1, rd2, wr2;
`endif
  always #5 clk = ~clk;
  line_mem_responder #(.LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
`ifdef LINE_MEM_STATS_EN
    , .rd_count_o (rd1), .wr_count_o (wr1)
`endif
  );
  line_mem_responder #(.LINE_W(256), .ADDR_W(32), .DEPTH(512), .LATENCY(1)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2)
`ifdef LINE_MEM_STATS_EN
    , .rd_count_o (rd2), .wr_count_o (wr2)
`endif
  );
  task automatic run_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                         input bit disturb, input string name);
    int idx;
    int n;
    bit bad_busy;
    logic [255:0] exp;
    idx = int'((a >> 5) % 512);
    sb.push_back(w ? last_rd : model[idx]);
    if (w) model[idx] = d;
    else last_rd = model[idx];
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = w;
    bus.mem_addr_i   = a;
    bus.mem_data_i   = d;
    n = 0;
    bad_busy = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.busy_o) bad_busy = 1'b1;
      if (disturb && n == 3) begin
        bus.mem_addr_i   = 32'h0000_00E0;
        bus.mem_write_i  = ~w;
        bus.mem_data_i   = {8{32'hDEAD_BEEF}};
        bus.mem_enable_i = 1'b0;
      end
    end while (!bus.mem_ack_o && n < 40);
    bus.mem_enable_i = 1'b0;
    checks++;
    if (bus.mem_ack_o !== 1'b1 || n != LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles (ack=%b), expected %0d", name, n, bus.mem_ack_o, LAT);
    end
    checks++;
    if (bad_busy) begin
      failures++;
      $display("FAIL %s busy: busy_o dropped before ack, expected high for %0d cycles", name, LAT);
    end
    exp = sb.pop_front();
    checks++;
    if (bus.mem_data_o !== exp) begin
      failures++;
      $display("FAIL %s data: got %h expected %h", name, bus.mem_data_o, exp);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s post_ack: ack=%b busy=%b expected 0 0", name, bus.mem_ack_o, bus.busy_o);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset ctrl: ack=%b busy=%b expected 0 0", bus.mem_ack_o, bus.busy_o);
    end
    checks++;
    if (bus.mem_data_o !== '0) begin
      failures++;
      $display("FAIL reset data: got %h expected 0", bus.mem_data_o);
    end
    checks++;
    if (bus2.mem_ack_o !== 1'b0 || bus2.busy_o !== 1'b0 || bus2.mem_data_o !== '0) begin
      failures++;
      $display("FAIL reset dut2: ack=%b busy=%b data=%h expected all 0", bus2.mem_ack_o, bus2.busy_o, bus2.mem_data_o);
    end
    rst_n = 1'b1;
    last_rd = '0;
  endtask
  task automatic test_read_latency();
    run_req(1'b0, 32'h0000_0060, '0, 1'b0, "read_line3");
  endtask
  task automatic test_write_read();
    run_req(1'b1, 32'h0000_0080, 256'h1234, 1'b0, "write_line4");
    run_req(1'b0, 32'h0000_0080, '0, 1'b0, "raw_line4");
  endtask
  task automatic test_ignore_inputs();
    run_req(1'b0, 32'h0000_0060, '0, 1'b1, "wait_ignores_inputs");
    run_req(1'b0, 32'h0000_00E0, '0, 1'b0, "line7_intact");
  endtask
  task automatic test_alias();
    run_req(1'b1, 32'h0000_4020, {4{64'hCAFE_F00D_0BAD_BEEF}}, 1'b0, "alias_write");
    run_req(1'b0, 32'h0000_0020, '0, 1'b0, "alias_read");
  endtask
  task automatic test_reset_mid_write();
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = 1'b1;
    bus.mem_addr_i   = 32'h0000_0120;
    bus.mem_data_i   = '1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    bus.mem_enable_i = 1'b0;
    #1;
    checks++;
    if (bus.mem_ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: ack=%b busy=%b expected 0 0", bus.mem_ack_o, bus.busy_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    repeat (LAT + 2) @(negedge clk);
    checks++;
    if (bus.mem_ack_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_after: ack=%b busy=%b expected 0 0", bus.mem_ack_o, bus.busy_o);
    end
    run_req(1'b0, 32'h0000_0120, '0, 1'b0, "line9_retained");
  endtask
  task automatic test_back_to_back();
    logic [255:0] exp;
    @(negedge clk);
    bus2.mem_enable_i = 1'b1;
    bus2.mem_write_i  = 1'b0;
    bus2.mem_addr_i   = 32'h0000_0060;
    bus2.mem_data_i   = '0;
    sb.push_back(PAT2);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (bus2.mem_ack_o !== 1'(k % 2)) begin
        failures++;
        $display("FAIL b2b ack cycle %0d: got %b expected %b", k, bus2.mem_ack_o, 1'(k % 2));
      end
      if (bus2.mem_ack_o === 1'b1 && sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        if (bus2.mem_data_o !== exp) begin
          failures++;
          $display("FAIL b2b data cycle %0d: got %h expected %h", k, bus2.mem_data_o, exp);
        end
        if (k < 7) sb.push_back(PAT2);
      end
    end
    bus2.mem_enable_i = 1'b0;
`ifdef LINE_MEM_STATS_EN
    checks++;
    if (rd2 !== 32'd4 || wr2 !== 32'd0) begin
      failures++;
      $display("FAIL b2b stats: rd=%0d wr=%0d expected 4 0", rd2, wr2);
    end
`endif
  endtask
  initial begin
    bus.mem_enable_i = 1'b0;
    bus.mem_write_i  = 1'b0;
    bus.mem_addr_i   = '0;
    bus.mem_data_i   = '0;
    bus2.mem_enable_i = 1'b0;
    bus2.mem_write_i  = 1'b0;
    bus2.mem_addr_i   = '0;
    bus2.mem_data_i   = '0;
    dut.u_array.mem[3] = PAT3;
    dut.u_array.mem[7] = PAT7;
    dut.u_array.mem[9] = PAT9;
    dut2.u_array.mem[3] = PAT2;
    model[3] = PAT3;
    model[7] = PAT7;
    model[9] = PAT9;
    test_reset();
    test_read_latency();
    test_write_read();
    test_ignore_inputs();
    test_alias();
    test_reset_mid_write();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
